// File: rtl/imm_decode_stage.sv
// RISC-V immediate-decode stage: decodes I/S/B/U/J immediates and PC-relative targets behind a 2-entry skid buffer.
// Optional IMM_DECODE_ILLEGAL_EN adds a registered out_illegal flag.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target
`ifdef IMM_DECODE_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  entry_t     dec_d;
  entry_t     out_q;
  entry_t     skid_q;
  logic       out_valid_q;
  logic       skid_valid_q;
  logic [6:0] opcode;
  logic [63:0] imm64;
  logic       pc_rel;
  logic       accept;

  assign opcode = in_inst[6:0];

  // Immediates are built at 64 bits and truncated, so XLEN=32 and XLEN=64 share one path.
  always_comb begin
    imm64   = '0;
    pc_rel  = 1'b0;
    dec_d   = '0;
    dec_d.fmt = FMT_NONE;
    unique case (opcode)
      7'b0010011, 7'b0000011, 7'b0011011, 7'b1100111: begin
        dec_d.fmt = FMT_I;
        imm64     = {{52{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: begin
        dec_d.fmt = FMT_S;
        imm64     = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_d.fmt = FMT_B;
        imm64     = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
        pc_rel    = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        dec_d.fmt = FMT_U;
        imm64     = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
        pc_rel    = (opcode == 7'b0010111);
      end
      7'b1101111: begin
        dec_d.fmt = FMT_J;
        imm64     = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
        pc_rel    = 1'b1;
      end
      default: begin
        dec_d.fmt = FMT_NONE;
        imm64     = '0;
      end
    endcase
    dec_d.inst   = in_inst;
    dec_d.pc     = in_pc;
    dec_d.imm    = imm64[XLEN-1:0];
    // JALR is excluded from pc_rel: its target depends on rs1.
    dec_d.target = pc_rel ? (in_pc + imm64[XLEN-1:0]) : '0;
`ifdef IMM_DECODE_ILLEGAL_EN
    dec_d.illegal = (dec_d.fmt == FMT_NONE) || (in_inst[1:0] != 2'b11) ||
                    ((XLEN == 32) && (opcode == 7'b0011011));
`else
    dec_d.illegal = 1'b0;
`endif
  end

  // Handshake: a transfer happens on an edge where valid && ready; in_ready depends only
  // on skid occupancy and rst, never on in_valid, so there is no combinational loop.
  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec_d;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_inst   = out_q.inst;
  assign out_pc     = out_q.pc;
  assign out_imm    = out_q.imm;
  assign out_fmt    = out_q.fmt;
  assign out_target = out_q.target;
`ifdef IMM_DECODE_ILLEGAL_EN
  assign out_illegal = out_q.illegal;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vectors, back-pressure ordering, flush and reset.
module tb_imm_decode_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
`ifdef IMM_DECODE_ILLEGAL_EN
  logic            out_illegal;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [XLEN-1:0] exp_q[$];

  imm_decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target)
`ifdef IMM_DECODE_ILLEGAL_EN
    , .out_illegal(out_illegal)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    logic [63:0] t;
    t = {{32{v[31]}}, v};
    return t[XLEN-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic check_out(input string tag, input logic [XLEN-1:0] imm,
                           input logic [2:0] fmt, input logic [XLEN-1:0] target);
    check({tag, "_valid"},  64'(out_valid),  64'd1);
    check({tag, "_imm"},    64'(out_imm),    64'(imm));
    check({tag, "_fmt"},    64'(out_fmt),    64'(fmt));
    check({tag, "_target"}, 64'(out_target), 64'(target));
  endtask

  task automatic check_pop(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'(out_imm), 64'hDEAD_BEEF_DEAD_BEEF);
    end else begin
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_imm"}, 64'(out_imm), 64'(exp_q.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_fmt", 64'(out_fmt), 64'd0);
    check("rst_out_target", 64'(out_target), 64'd0);
`ifdef IMM_DECODE_ILLEGAL_EN
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Streaming decode with out_ready held high: each output follows its offer by one edge.
    out_ready = 1'b1;
    offer(32'hFFF0_0093, sx(32'h0000_0000));
    tick();
    check_out("addi", sx(32'hFFFF_FFFF), 3'd1, '0);
    check("addi_inst", 64'(out_inst), 64'hFFF0_0093);
`ifdef IMM_DECODE_ILLEGAL_EN
    check("addi_illegal", 64'(out_illegal), 64'd0);
`endif
    offer(32'hFE00_0EE3, sx(32'h0000_0100));
    tick();
    check_out("beq", sx(32'hFFFF_FFFC), 3'd3, sx(32'h0000_00FC));
    offer(32'h0010_00EF, sx(32'hFFFF_F900));
    tick();
    check_out("jal", sx(32'h0000_0800), 3'd5, sx(32'h0000_0100));
    check("jal_pc", 64'(out_pc), 64'(sx(32'hFFFF_F900)));
    offer(32'h0000_1297, sx(32'h0000_0300));
    tick();
    check_out("auipc", sx(32'h0000_1000), 3'd4, sx(32'h0000_1300));
    offer(32'h0040_8067, sx(32'h0000_0400));
    tick();
    check_out("jalr", sx(32'h0000_0004), 3'd1, '0);
    offer(32'h0000_007F, sx(32'h0000_0404));
    tick();
    check_out("unmapped", '0, 3'd0, '0);
`ifdef IMM_DECODE_ILLEGAL_EN
    check("unmapped_illegal", 64'(out_illegal), 64'd1);
`endif
    in_valid = 1'b0;
    tick();
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Back-pressure: two accepts fill output + skid, the third entry waits at the input.
    out_ready = 1'b0;
    exp_q.push_back(sx(32'h1234_5000));
    exp_q.push_back(sx(32'h0000_0008));
    exp_q.push_back(sx(32'hFFFF_FFFF));
    offer(32'h1234_52B7, sx(32'h0000_0200));
    tick();
    check("bp1_in_ready", 64'(in_ready), 64'd1);
    check_out("lui", sx(32'h1234_5000), 3'd4, '0);
    offer(32'h0020_A423, sx(32'h0000_0204));
    tick();
    check("bp2_in_ready", 64'(in_ready), 64'd0);
    offer(32'hFFF0_0093, sx(32'h0000_0208));
    tick();
    check("bp3_in_ready", 64'(in_ready), 64'd0);
    check("bp3_stable_imm", 64'(out_imm), 64'(sx(32'h1234_5000)));
    check("bp3_stable_pc", 64'(out_pc), 64'(sx(32'h0000_0200)));
    out_ready = 1'b1;
    #1;
    check_pop("bp_first");
    tick();
    check_pop("bp_second");
    check("bp_second_fmt", 64'(out_fmt), 64'd2);
    check("bp_second_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_pop("bp_third");
    check("bp_third_pc", 64'(out_pc), 64'(sx(32'h0000_0208)));
    tick();
    check("bp_end_out_valid", 64'(out_valid), 64'd0);
    check("bp_queue_left", 64'(exp_q.size()), 64'd0);

    // Flush with both registers full and a pending input entry.
    out_ready = 1'b0;
    offer(32'h1234_52B7, sx(32'h0000_0500));
    tick();
    offer(32'h0020_A423, sx(32'h0000_0504));
    tick();
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    offer(32'hFFF0_0093, sx(32'h0000_0508));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_data_kept", 64'(out_imm), 64'(sx(32'h1234_5000)));
    out_ready = 1'b1;
    tick();
    check("fl_after1_out_valid", 64'(out_valid), 64'd0);
    tick();
    check("fl_after2_out_valid", 64'(out_valid), 64'd0);

    // Flush coinciding with an accept drops the accepted entry.
    offer(32'h0010_00EF, sx(32'h0000_0600));
    flush = 1'b1;
    #1;
    check("fla_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fla_out_valid", 64'(out_valid), 64'd0);

    // Reset mid-operation discards held entries and clears data.
    out_ready = 1'b0;
    offer(32'h1234_52B7, sx(32'h0000_0700));
    tick();
    check("mr_loaded", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_out_imm", 64'(out_imm), 64'd0);
    check("mr_out_pc", 64'(out_pc), 64'd0);
    rst = 1'b0;
    #1;
    check("mr_in_ready", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
